// File: rtl/rs_alu.sv
// rs_alu: ALU reservation station (dispatch, tag wakeup, lowest-index issue); define RS_WAKEUP_BYPASS_EN to issue on the broadcast edge
module rs_alu #(
  parameter int RS_SIZE = 16,
  parameter int OP_W    = 5,
  parameter int DAT_W   = 32,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             iDP_En,
  input  logic [OP_W-1:0]  iDP_Op,
  input  logic [DAT_W-1:0] iDP_Pc,
  input  logic [DAT_W-1:0] iDP_Imm,
  input  logic             iDP_Rdy1,
  input  logic [DAT_W-1:0] iDP_Vs1,
  input  logic [TAG_W-1:0] iDP_Qs1,
  input  logic             iDP_Rdy2,
  input  logic [DAT_W-1:0] iDP_Vs2,
  input  logic [TAG_W-1:0] iDP_Qs2,
  input  logic [TAG_W-1:0] iDP_Qd,
  output logic             oDP_Full,
  input  logic             iEX_En,
  input  logic [TAG_W-1:0] iEX_Qd,
  input  logic [DAT_W-1:0] iEX_Vd,
  input  logic             iLSB_En,
  input  logic [TAG_W-1:0] iLSB_Qd,
  input  logic [DAT_W-1:0] iLSB_Vd,
  input  logic             iROB_Clr,
  output logic             oEX_En,
  output logic [OP_W-1:0]  oEX_Op,
  output logic [DAT_W-1:0] oEX_Pc,
  output logic [DAT_W-1:0] oEX_Imm,
  output logic [DAT_W-1:0] oEX_Vs1,
  output logic [DAT_W-1:0] oEX_Vs2,
  output logic [TAG_W-1:0] oEX_Qd
);
  localparam int IW = $clog2(RS_SIZE);
  logic [RS_SIZE-1:0] busy_q, busy_d, r1_q, r1_d, r2_q, r2_d;
  logic [OP_W-1:0]  op_q [RS_SIZE], op_d [RS_SIZE];
  logic [DAT_W-1:0] pc_q [RS_SIZE], pc_d [RS_SIZE], imm_q [RS_SIZE], imm_d [RS_SIZE];
  logic [DAT_W-1:0] vs1_q [RS_SIZE], vs1_d [RS_SIZE], vs2_q [RS_SIZE], vs2_d [RS_SIZE];
  logic [TAG_W-1:0] qs1_q [RS_SIZE], qs1_d [RS_SIZE], qs2_q [RS_SIZE], qs2_d [RS_SIZE];
  logic [TAG_W-1:0] qd_q [RS_SIZE], qd_d [RS_SIZE];
  logic             ex_en_q, ex_en_d;
  logic [OP_W-1:0]  ex_op_q, ex_op_d;
  logic [DAT_W-1:0] ex_pc_q, ex_pc_d, ex_imm_q, ex_imm_d, ex_vs1_q, ex_vs1_d, ex_vs2_q, ex_vs2_d;
  logic [TAG_W-1:0] ex_qd_q, ex_qd_d;
  logic [RS_SIZE-1:0] h1, h2, rd1, rd2, cand;
  logic [DAT_W-1:0] b1 [RS_SIZE], b2 [RS_SIZE];
  logic             dh1, dh2, full, found;
  logic [DAT_W-1:0] db1, db2;
  logic [IW-1:0]    sel, fi;
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      h1[i] = (iEX_En && iEX_Qd == qs1_q[i]) || (iLSB_En && iLSB_Qd == qs1_q[i]);
      b1[i] = (iEX_En && iEX_Qd == qs1_q[i]) ? iEX_Vd : iLSB_Vd;
      h2[i] = (iEX_En && iEX_Qd == qs2_q[i]) || (iLSB_En && iLSB_Qd == qs2_q[i]);
      b2[i] = (iEX_En && iEX_Qd == qs2_q[i]) ? iEX_Vd : iLSB_Vd;
    end
    dh1 = (iEX_En && iEX_Qd == iDP_Qs1) || (iLSB_En && iLSB_Qd == iDP_Qs1);
    db1 = (iEX_En && iEX_Qd == iDP_Qs1) ? iEX_Vd : iLSB_Vd;
    dh2 = (iEX_En && iEX_Qd == iDP_Qs2) || (iLSB_En && iLSB_Qd == iDP_Qs2);
    db2 = (iEX_En && iEX_Qd == iDP_Qs2) ? iEX_Vd : iLSB_Vd;
  end
`ifdef RS_WAKEUP_BYPASS_EN
  assign rd1 = r1_q | h1;
  assign rd2 = r2_q | h2;
`else
  assign rd1 = r1_q;
  assign rd2 = r2_q;
`endif
  assign cand  = busy_q & rd1 & rd2;
  assign found = |cand;
  assign full  = &busy_q;
  always_comb begin
    sel = '0;
    fi  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (cand[i]) sel = IW'(i);
      if (!busy_q[i]) fi = IW'(i);
    end
  end
  always_comb begin
    busy_d = busy_q; r1_d = r1_q; r2_d = r2_q;
    op_d = op_q; pc_d = pc_q; imm_d = imm_q; vs1_d = vs1_q; vs2_d = vs2_q;
    qs1_d = qs1_q; qs2_d = qs2_q; qd_d = qd_q;
    ex_en_d = ex_en_q; ex_op_d = ex_op_q; ex_pc_d = ex_pc_q; ex_imm_d = ex_imm_q;
    ex_vs1_d = ex_vs1_q; ex_vs2_d = ex_vs2_q; ex_qd_d = ex_qd_q;
    if (en) begin
      ex_en_d = 1'b0;
      if (iROB_Clr) begin
        busy_d = '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy_q[i] && !r1_q[i] && h1[i]) begin
            r1_d[i]  = 1'b1;
            vs1_d[i] = b1[i];
          end
          if (busy_q[i] && !r2_q[i] && h2[i]) begin
            r2_d[i]  = 1'b1;
            vs2_d[i] = b2[i];
          end
        end
        if (found) begin
          ex_en_d      = 1'b1;
          ex_op_d      = op_q[sel];
          ex_pc_d      = pc_q[sel];
          ex_imm_d     = imm_q[sel];
          ex_vs1_d     = r1_q[sel] ? vs1_q[sel] : b1[sel];
          ex_vs2_d     = r2_q[sel] ? vs2_q[sel] : b2[sel];
          ex_qd_d      = qd_q[sel];
          busy_d[sel]  = 1'b0;
        end
        if (iDP_En && !full) begin
          busy_d[fi] = 1'b1;
          op_d[fi]   = iDP_Op;
          pc_d[fi]   = iDP_Pc;
          imm_d[fi]  = iDP_Imm;
          r1_d[fi]   = iDP_Rdy1 || dh1;
          vs1_d[fi]  = iDP_Rdy1 ? iDP_Vs1 : db1;
          qs1_d[fi]  = iDP_Qs1;
          r2_d[fi]   = iDP_Rdy2 || dh2;
          vs2_d[fi]  = iDP_Rdy2 ? iDP_Vs2 : db2;
          qs2_d[fi]  = iDP_Qs2;
          qd_d[fi]   = iDP_Qd;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0; ex_en_q <= 1'b0; ex_op_q <= '0; ex_pc_q <= '0; ex_imm_q <= '0;
      ex_vs1_q <= '0; ex_vs2_q <= '0; ex_qd_q <= '0;
    end else begin
      busy_q <= busy_d; r1_q <= r1_d; r2_q <= r2_d;
      op_q <= op_d; pc_q <= pc_d; imm_q <= imm_d; vs1_q <= vs1_d; vs2_q <= vs2_d;
      qs1_q <= qs1_d; qs2_q <= qs2_d; qd_q <= qd_d;
      ex_en_q <= ex_en_d; ex_op_q <= ex_op_d; ex_pc_q <= ex_pc_d; ex_imm_q <= ex_imm_d;
      ex_vs1_q <= ex_vs1_d; ex_vs2_q <= ex_vs2_d; ex_qd_q <= ex_qd_d;
    end
  end
  assign oDP_Full = full;
  assign oEX_En   = ex_en_q;
  assign oEX_Op   = ex_op_q;
  assign oEX_Pc   = ex_pc_q;
  assign oEX_Imm  = ex_imm_q;
  assign oEX_Vs1  = ex_vs1_q;
  assign oEX_Vs2  = ex_vs2_q;
  assign oEX_Qd   = ex_qd_q;
endmodule

// File: tb/tb_rs_alu.sv
// tb_rs_alu: scoreboard bench for rs_alu against a behavioural reservation-station model
module tb_rs_alu;
  logic clk = 1'b0;
  logic rst, en, iDP_En, iDP_Rdy1, iDP_Rdy2, iEX_En, iLSB_En, iROB_Clr;
  logic [4:0] iDP_Op;
  logic [31:0] iDP_Pc, iDP_Imm, iDP_Vs1, iDP_Vs2, iEX_Vd, iLSB_Vd;
  logic [3:0] iDP_Qs1, iDP_Qs2, iDP_Qd, iEX_Qd, iLSB_Qd;
  logic oDP_Full, oEX_En;
  logic [4:0] oEX_Op;
  logic [31:0] oEX_Pc, oEX_Imm, oEX_Vs1, oEX_Vs2;
  logic [3:0] oEX_Qd;
`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  rs_alu dut (
    .clk(clk), .rst(rst), .en(en),
    .iDP_En(iDP_En), .iDP_Op(iDP_Op), .iDP_Pc(iDP_Pc), .iDP_Imm(iDP_Imm),
    .iDP_Rdy1(iDP_Rdy1), .iDP_Vs1(iDP_Vs1), .iDP_Qs1(iDP_Qs1),
    .iDP_Rdy2(iDP_Rdy2), .iDP_Vs2(iDP_Vs2), .iDP_Qs2(iDP_Qs2),
    .iDP_Qd(iDP_Qd), .oDP_Full(oDP_Full),
    .iEX_En(iEX_En), .iEX_Qd(iEX_Qd), .iEX_Vd(iEX_Vd),
    .iLSB_En(iLSB_En), .iLSB_Qd(iLSB_Qd), .iLSB_Vd(iLSB_Vd),
    .iROB_Clr(iROB_Clr), .oEX_En(oEX_En), .oEX_Op(oEX_Op), .oEX_Pc(oEX_Pc),
    .oEX_Imm(oEX_Imm), .oEX_Vs1(oEX_Vs1), .oEX_Vs2(oEX_Vs2), .oEX_Qd(oEX_Qd)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit busy, r1, r2;
    logic [4:0] op;
    logic [31:0] pc, imm, v1, v2;
    logic [3:0] q1, q2, qd;
  } ent_t;
  typedef struct {
    int stamp;
    logic [4:0] op;
    logic [31:0] pc, imm, v1, v2;
    logic [3:0] qd;
  } exp_t;
  ent_t m [16];
  exp_t sb [$];
  exp_t mon_e;
  int edge_n = 0, n_chk = 0, n_fail = 0;
  bit eff;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask
  function automatic bit bc(input logic [3:0] t, output logic [31:0] v);
    v = '0;
    if (iEX_En && iEX_Qd == t) begin v = iEX_Vd; return 1'b1; end
    if (iLSB_En && iLSB_Qd == t) begin v = iLSB_Vd; return 1'b1; end
    return 1'b0;
  endfunction
  function automatic bit model_full();
    for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
    return 1'b1;
  endfunction
  // Advance the model over the coming edge using the inputs currently driven.
  task automatic model_step();
    bit full, h1, h2;
    logic [31:0] w1, w2;
    int s, f;
    exp_t e;
    if (!rst) begin
      foreach (m[i]) m[i].busy = 1'b0;
      return;
    end
    if (!en) return;
    full = model_full();
    f = -1;
    for (int i = 15; i >= 0; i--) if (!m[i].busy) f = i;
    chk("full flag", oDP_Full, full);
    if (iDP_En && full) $display("note: protocol violation, dispatch while full before edge %0d is dropped", edge_n + 1);
    if (iROB_Clr) begin
      foreach (m[i]) m[i].busy = 1'b0;
      return;
    end
    s = -1;
    for (int i = 0; i < 16; i++) begin
      h1 = bc(m[i].q1, w1);
      h2 = bc(m[i].q2, w2);
      if (s < 0 && m[i].busy && (m[i].r1 || (BYP && h1)) && (m[i].r2 || (BYP && h2))) begin
        s = i;
        e.stamp = edge_n + 1;
        e.op = m[i].op; e.pc = m[i].pc; e.imm = m[i].imm; e.qd = m[i].qd;
        e.v1 = m[i].r1 ? m[i].v1 : w1;
        e.v2 = m[i].r2 ? m[i].v2 : w2;
        sb.push_back(e);
      end
    end
    for (int i = 0; i < 16; i++) if (m[i].busy) begin
      if (!m[i].r1 && bc(m[i].q1, w1)) begin m[i].r1 = 1'b1; m[i].v1 = w1; end
      if (!m[i].r2 && bc(m[i].q2, w2)) begin m[i].r2 = 1'b1; m[i].v2 = w2; end
    end
    if (s >= 0) m[s].busy = 1'b0;
    if (iDP_En && f >= 0) begin
      m[f].busy = 1'b1; m[f].op = iDP_Op; m[f].pc = iDP_Pc; m[f].imm = iDP_Imm; m[f].qd = iDP_Qd;
      m[f].r1 = iDP_Rdy1 || bc(iDP_Qs1, w1); m[f].v1 = iDP_Rdy1 ? iDP_Vs1 : w1; m[f].q1 = iDP_Qs1;
      m[f].r2 = iDP_Rdy2 || bc(iDP_Qs2, w2); m[f].v2 = iDP_Rdy2 ? iDP_Vs2 : w2; m[f].q2 = iDP_Qs2;
    end
  endtask
  always @(posedge clk) begin
    eff = rst && en;
    #1;
    if (eff) begin
      edge_n++;
      while (sb.size() > 0 && sb[0].stamp < edge_n) begin
        mon_e = sb.pop_front();
        chk("missed issue edge", edge_n, mon_e.stamp);
      end
      if (oEX_En) begin
        if (sb.size() == 0 || sb[0].stamp != edge_n) chk("spurious issue", oEX_En, 0);
        else begin
          mon_e = sb.pop_front();
          chk("issue op", oEX_Op, mon_e.op);
          chk("issue pc", oEX_Pc, mon_e.pc);
          chk("issue imm", oEX_Imm, mon_e.imm);
          chk("issue vs1", oEX_Vs1, mon_e.v1);
          chk("issue vs2", oEX_Vs2, mon_e.v2);
          chk("issue qd", oEX_Qd, mon_e.qd);
        end
      end
    end
  end
  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
  endtask
  task automatic idle();
    rst = 1'b1; en = 1'b1; iDP_En = 1'b0; iEX_En = 1'b0; iLSB_En = 1'b0; iROB_Clr = 1'b0;
  endtask
  task automatic dp(input logic [4:0] op, input logic [31:0] pc, imm,
                    input logic r1, input logic [31:0] v1, input logic [3:0] q1,
                    input logic r2, input logic [31:0] v2, input logic [3:0] q2, input logic [3:0] qd);
    iDP_En = 1'b1; iDP_Op = op; iDP_Pc = pc; iDP_Imm = imm;
    iDP_Rdy1 = r1; iDP_Vs1 = v1; iDP_Qs1 = q1;
    iDP_Rdy2 = r2; iDP_Vs2 = v2; iDP_Qs2 = q2; iDP_Qd = qd;
  endtask
  initial begin
    idle();
    iEX_Qd = '0; iEX_Vd = '0; iLSB_Qd = '0; iLSB_Vd = '0;
    rst = 1'b0;
    dp(5'd3, 32'h40, 32'h1, 1, 32'h11, 0, 1, 32'h22, 0, 4'd1);
    tick(); tick();
    chk("reset en", oEX_En, 0);
    chk("reset full", oDP_Full, 0);
    chk("reset vs1", oEX_Vs1, 0);
    chk("reset pc", oEX_Pc, 0);
    chk("reset qd", oEX_Qd, 0);
    idle(); tick(); tick();
    chk("post-reset idle en", oEX_En, 0);
    chk("post-reset full", oDP_Full, 0);
    dp(5'b01011, 32'h100, 32'd7, 1, 32'd5, 0, 1, 32'd0, 0, 4'd3);
    tick(); idle();
    chk("addi not yet issued", oEX_En, 0);
    tick();
    chk("addi en", oEX_En, 1);
    chk("addi op", oEX_Op, 5'b01011);
    chk("addi vs1", oEX_Vs1, 5);
    chk("addi imm", oEX_Imm, 7);
    chk("addi qd", oEX_Qd, 3);
    tick();
    chk("addi en drop", oEX_En, 0);
    dp(5'b00000, 32'h104, 32'd0, 0, 32'd0, 4'd6, 1, 32'd2, 0, 4'd4);
    tick(); idle(); tick();
    iEX_En = 1'b1; iEX_Qd = 4'd6; iEX_Vd = 32'd40;
    tick(); idle();
    chk("wakeup issue on broadcast edge", oEX_En, BYP);
    tick();
    chk("wakeup issue one edge later", oEX_En, !BYP);
    chk("wakeup vs1", oEX_Vs1, 40);
    chk("wakeup vs2", oEX_Vs2, 2);
    dp(5'b00010, 32'h108, 32'd0, 0, 32'd0, 4'd1, 0, 32'd0, 4'd2, 4'd5);
    iEX_En = 1'b1; iEX_Qd = 4'd1; iEX_Vd = 32'd9;
    iLSB_En = 1'b1; iLSB_Qd = 4'd2; iLSB_Vd = 32'd4;
    tick(); idle(); tick();
    chk("capture en", oEX_En, 1);
    chk("capture vs1", oEX_Vs1, 9);
    chk("capture vs2", oEX_Vs2, 4);
    tick();
    for (int i = 0; i < 16; i++) begin
      dp(5'(i), 32'(i * 4), 32'(i), 0, 32'd0, (i == 0) ? 4'd5 : 4'd9, 1, 32'(i), 0, 4'(i));
      tick();
    end
    chk("full after 16", oDP_Full, 1);
    dp(5'd31, 32'hdead, 32'd0, 1, 32'd1, 0, 1, 32'd1, 0, 4'd15);
    tick(); idle();
    chk("full after dropped dispatch", oDP_Full, 1);
    iEX_En = 1'b1; iEX_Qd = 4'd5; iEX_Vd = 32'd77;
    tick(); idle();
    chk("full after wake edge", oDP_Full, !BYP);
    tick();
    chk("full released", oDP_Full, 0);
    chk("entry0 vs1", oEX_Vs1, 77);
    iEX_En = 1'b1; iEX_Qd = 4'd9; iEX_Vd = 32'd1;
    tick(); idle();
    repeat (17) tick();
    chk("drained full", oDP_Full, 0);
    for (int i = 0; i < 3; i++) begin
      dp(5'd1, 32'h200 + 32'(i), 32'd0, 0, 32'd0, 4'd7, 1, 32'd3, 0, 4'(i));
      tick();
    end
    idle();
    iEX_En = 1'b1; iEX_Qd = 4'd7; iEX_Vd = 32'd3;
    tick(); idle();
    iROB_Clr = 1'b1;
    dp(5'd2, 32'h300, 32'd0, 1, 32'd1, 0, 1, 32'd1, 0, 4'd8);
    tick(); idle();
    chk("flush en", oEX_En, 0);
    chk("flush full", oDP_Full, 0);
    repeat (3) begin
      tick();
      chk("after flush en", oEX_En, 0);
    end
    repeat (3000) begin
      idle();
      en = ($urandom_range(0, 9) != 0);
      iROB_Clr = ($urandom_range(0, 49) == 0);
      if (!model_full() && $urandom_range(0, 1) == 1)
        dp(5'($urandom), $urandom, $urandom, $urandom_range(0, 9) < 4, $urandom, 4'($urandom),
           $urandom_range(0, 9) < 4, $urandom, 4'($urandom), 4'($urandom));
      iEX_En = ($urandom_range(0, 2) == 0); iEX_Qd = 4'($urandom); iEX_Vd = $urandom;
      iLSB_En = ($urandom_range(0, 2) == 0); iLSB_Qd = 4'($urandom); iLSB_Vd = $urandom;
      if (iLSB_Qd == iEX_Qd) iLSB_Qd = iEX_Qd + 4'd1;
      tick();
    end
    idle();
    tick(); tick();
    chk("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
